filtez: RTL and testbench
=========================

// Module: filtez
// PURPOSE
//  ADPCM zero-section predictor: reads the 6-tap coefficient array bli[] and
//  the quantised-difference delay line dlti[] that the coefficient-update block
//  writes. Computes zl = sum(bli[i]*dlti[i]) and returns zl >>> 14.
//  It is the read side of the shared bli/dlti RAM interface and is started once
//  per sample through the ap_start/ap_done handshake, before the next update.
// PARAMETERS
//  TAPS    6   number of taps read, addresses 0..TAPS-1
//  DATA_W  32  width of bli_q0, dlti_q0 and ap_return
//  ADDR_W  3   RAM address width
//  ACC_W   64  signed accumulator width
//  SHIFT   14  arithmetic right shift applied to the final sum
// PORTS
//  ap_clk         in   1       clock; every register updates on the rising edge
//  ap_rst         in   1       asynchronous, active-high reset
//  ap_start       in   1       start request; sampled only in S_IDLE
//  ap_done        out  1       result valid, one cycle
//  ap_idle        out  1       block is idle
//  ap_ready       out  1       new start may be accepted next cycle, one cycle
//  bli_address0   out  ADDR_W  coefficient RAM read address
//  bli_ce0        out  1       coefficient RAM enable; read data arrives the next cycle
//  bli_q0         in   DATA_W  coefficient read data, signed
//  dlti_address0  out  ADDR_W  delay-line RAM read address
//  dlti_ce0       out  1       delay-line RAM enable; read data arrives the next cycle
//  dlti_q0        in   DATA_W  delay-line read data, signed
//  ap_return      out  DATA_W  filter output; held until the next S_DONE
// BEHAVIOUR
//  - Reset values: all outputs 0 except ap_idle, which follows its rule; acc=0,
//    i=0, state=S_IDLE. Reset asserted mid-run aborts the run, and no ap_done is issued.
//  - One-hot FSM with states S_IDLE, S_FETCH, S_MAC, S_DONE.
//  - S_IDLE:
//      ap_idle = ~ap_start.
//      ap_start=1 -> clear acc, set i=0, go to S_FETCH.
//  - S_FETCH:
//      bli_ce0 = dlti_ce0 = 1, both addresses = i.
//      Go to S_MAC.
//  - S_MAC:
//      acc += signed(bli_q0) * signed(dlti_q0), full 64-bit product.
//      i = i+1.
//      If the new i == TAPS go to S_DONE, else go to S_FETCH.
//  - S_DONE:
//      ap_return <= acc[SHIFT+DATA_W-1:SHIFT], an arithmetic shift (floor for negatives).
//      ap_done = ap_ready = 1 for one cycle, then go to S_IDLE.
//  - Latency: start accepted at cycle 0; FETCH/MAC pairs cover cycles 1..12;
//    S_DONE at cycle 13. A start held high restarts at cycle 14.
//  - ap_start changes during a run are ignored.
//  - RAM enables are 0 outside S_FETCH; addresses are don't-care when ce=0.
//  - The block never writes to either RAM.
//  - Accumulator overflow wraps modulo 2^ACC_W; this cannot occur for
//    G.722-range data.
// CONFIGURATION
//  FILTEZ_SAT_EN defined:
//    if acc>>>SHIFT exceeds the signed DATA_W range, ap_return saturates to
//    0x7FFFFFFF / 0x80000000.
//  FILTEZ_SAT_EN undefined:
//    ap_return is the low DATA_W bits of acc>>>SHIFT (wrap).
//  Latency is identical in both modes.
// STRUCTURE
//  - Shared package adpcm_pkg:
//    ADPCM_TAPS=6, ADPCM_ADDR_W=3, ADPCM_DATA_W=32, FILTEZ_SHIFT=14.
//    FSM state encoding typedef filtez_state_t.
//  - One sub-module, filtez_mac:
//    signed 32x32 multiply-accumulate with clear/enable inputs, registered acc.
//  - The FSM and handshake live in the top level.
// TESTING
//  1. All RAM words 0, pulse ap_start -> ap_done at cycle 13, ap_return=0,
//     ap_idle=1 afterwards.
//  2. bli[i]=16384, dlti[i]=i+1 for i=0..5 -> ap_return=21.
//     Check address sequence 0..5 with ce only in S_FETCH.
//  3. bli[0]=-16384, dlti[0]=3, others 0 -> -3.
//     bli[0]=1, dlti[0]=-1, others 0 -> -1 (floor).
//  4. bli[0]=dlti[0]=0x40000000, others 0 -> ap_return=0x00000000 without
//     FILTEZ_SAT_EN, 0x7FFFFFFF with it.
//  5. Assert ap_rst at cycle 5 of a run -> all outputs 0, no ap_done.
//     Rerun test 2 after release -> 21.
//  6. Hold ap_start high for 3 runs with dlti changed between them ->
//     ap_done pulses at cycles 13, 27, 41 with the matching results.

Source files
------------

// File: rtl/adpcm_pkg.sv
// adpcm_pkg: shared ADPCM constants and the filtez FSM state encoding
package adpcm_pkg;
    localparam int ADPCM_TAPS   = 6;
    localparam int ADPCM_ADDR_W = 3;
    localparam int ADPCM_DATA_W = 32;
    localparam int ADPCM_ACC_W  = 64;
    localparam int FILTEZ_SHIFT = 14;
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_FETCH = 4'b0010,
        S_MAC   = 4'b0100,
        S_DONE  = 4'b1000
    } filtez_state_t;
endpackage

// File: rtl/filtez_mac.sv
// filtez_mac: signed multiply-accumulate with clear/enable and scaled result output
//   clk_i, rst_i  clock, asynchronous active-high reset
//   clr_i         zero the accumulator (wins over en_i)
//   en_i          add a_i*b_i to the accumulator
//   a_i, b_i      signed operands
//   res_o         acc >>> SHIFT truncated to DATA_W, saturated when FILTEZ_SAT_EN is defined
module filtez_mac #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64,
    parameter int SHIFT  = 14
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [DATA_W-1:0] b_i,
    output logic        [DATA_W-1:0] res_o
);
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    assign prod  = a_i * b_i;
    assign acc_d = clr_i ? '0 : en_i ? acc_q + ACC_W'(prod) : acc_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) acc_q <= '0;
        else       acc_q <= acc_d;
    end
`ifdef FILTEZ_SAT_EN
    // the shifted value fits DATA_W signed bits only if everything above its sign bit matches it
    logic fits;
    assign fits  = (&acc_q[ACC_W-1:SHIFT+DATA_W-1]) | ~(|acc_q[ACC_W-1:SHIFT+DATA_W-1]);
    assign res_o = fits ? acc_q[SHIFT+DATA_W-1:SHIFT] : {acc_q[ACC_W-1], {(DATA_W-1){~acc_q[ACC_W-1]}}};
`else
    assign res_o = acc_q[SHIFT+DATA_W-1:SHIFT];
`endif
endmodule

// File: rtl/filtez.sv
// filtez: ADPCM zero-section predictor, returns sum(bli[i]*dlti[i]) >>> 14 over 6 taps
//   ap_clk, ap_rst               clock, asynchronous active-high reset
//   ap_start/ap_done/ap_idle/ap_ready  block-level handshake
//   bli_address0/ce0/q0          coefficient RAM read port (1-cycle read latency)
//   dlti_address0/ce0/q0         delay-line RAM read port (1-cycle read latency)
//   ap_return                    result, valid with ap_done and held until the next one
//   FILTEZ_SAT_EN                define to saturate ap_return instead of wrapping
module filtez
    import adpcm_pkg::*;
#(
    parameter int TAPS   = ADPCM_TAPS,
    parameter int DATA_W = ADPCM_DATA_W,
    parameter int ADDR_W = ADPCM_ADDR_W,
    parameter int ACC_W  = ADPCM_ACC_W,
    parameter int SHIFT  = FILTEZ_SHIFT
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic                     ap_start,
    output logic                     ap_done,
    output logic                     ap_idle,
    output logic                     ap_ready,
    output logic        [ADDR_W-1:0] bli_address0,
    output logic                     bli_ce0,
    input  logic signed [DATA_W-1:0] bli_q0,
    output logic        [ADDR_W-1:0] dlti_address0,
    output logic                     dlti_ce0,
    input  logic signed [DATA_W-1:0] dlti_q0,
    output logic        [DATA_W-1:0] ap_return
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPS - 1);
    filtez_state_t     state_q, state_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [DATA_W-1:0] ret_q, ret_d, res;
    logic              clr, en;
    filtez_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SHIFT(SHIFT)) u_mac (
        .clk_i (ap_clk),
        .rst_i (ap_rst),
        .clr_i (clr),
        .en_i  (en),
        .a_i   (bli_q0),
        .b_i   (dlti_q0),
        .res_o (res)
    );
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            ret_q   <= ret_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        ret_d    = ret_q;
        clr      = 1'b0;
        en       = 1'b0;
        ap_idle  = 1'b0;
        ap_done  = 1'b0;
        ap_ready = 1'b0;
        bli_ce0  = 1'b0;
        dlti_ce0 = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ap_idle = ~ap_start;
                if (ap_start) begin
                    clr     = 1'b1;
                    i_d     = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                bli_ce0  = 1'b1;
                dlti_ce0 = 1'b1;
                state_d  = S_MAC;
            end
            // read data for tap i arrives here, one cycle after its fetch
            S_MAC: begin
                en      = 1'b1;
                i_d     = i_q + 1'b1;
                state_d = (i_q == LAST) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                ret_d    = res;
                ap_done  = 1'b1;
                ap_ready = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    // present the fresh result during the ap_done cycle, the held copy otherwise
    assign ap_return     = (state_q == S_DONE) ? res : ret_q;
    assign bli_address0  = i_q;
    assign dlti_address0 = i_q;
endmodule

// File: tb/tb_filtez.sv
// tb_filtez: directed table-driven bench for filtez with RAM models
module tb_filtez;
    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        ap_start = 1'b0;
    logic        ap_done, ap_idle, ap_ready, bli_ce0, dlti_ce0;
    logic [2:0]  bli_address0, dlti_address0;
    logic [31:0] bli_q0, dlti_q0, ap_return;
    logic [31:0] bli_mem [6];
    logic [31:0] dlti_mem [6];
    int checks = 0;
    int errors = 0;

    filtez dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .ap_ready      (ap_ready),
        .bli_address0  (bli_address0),
        .bli_ce0       (bli_ce0),
        .bli_q0        (bli_q0),
        .dlti_address0 (dlti_address0),
        .dlti_ce0      (dlti_ce0),
        .dlti_q0       (dlti_q0),
        .ap_return     (ap_return)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) begin
        if (bli_ce0)  bli_q0  <= bli_mem[bli_address0];
        if (dlti_ce0) dlti_q0 <= dlti_mem[dlti_address0];
    end

    typedef struct {
        string           name;
        logic [5:0][31:0] b;
        logic [5:0][31:0] d;
        logic [31:0]      exp;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input vec_t v);
        for (int k = 0; k < 6; k++) begin
            bli_mem[k]  = v.b[k];
            dlti_mem[k] = v.d[k];
        end
    endtask

    task automatic run_vec(input vec_t v);
        int done_at = -1;
        load(v);
        @(negedge ap_clk);
        ap_start = 1'b1;
        #1 chk({v.name, " idle_at_start"}, 64'(ap_idle), 64'd0);
        for (int n = 1; n <= 20 && done_at < 0; n++) begin
            @(negedge ap_clk);
            ap_start = 1'b0;
            #1;
            if (ap_done) begin
                done_at = n;
                chk({v.name, " ret"}, 64'(ap_return), 64'(v.exp));
                chk({v.name, " ready"}, 64'(ap_ready), 64'd1);
            end else if (n < 13) begin
                chk({v.name, " ce"}, 64'({bli_ce0, dlti_ce0}), 64'({2{n[0]}}));
                if (n[0]) chk({v.name, " addr"}, 64'({bli_address0, dlti_address0}), 64'({2{3'((n - 1) / 2)}}));
            end
        end
        chk({v.name, " done_cycle"}, 64'(done_at), 64'(13));
        @(negedge ap_clk);
        #1;
        chk({v.name, " done_pulse"}, 64'(ap_done), 64'd0);
        chk({v.name, " idle_after"}, 64'(ap_idle), 64'd1);
        chk({v.name, " ret_held"}, 64'(ap_return), 64'(v.exp));
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic seen;
        int   at [3];
        logic [31:0] exp_seq [3];
        int   dn;
        vecs[0] = '{"zero", '0, '0, 32'h0};
        vecs[1] = '{"ramp", {6{32'd16384}}, {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 32'd21};
        vecs[2] = '{"neg", {160'd0, 32'hFFFFC000}, {160'd0, 32'd3}, 32'hFFFFFFFD};
        vecs[3] = '{"floor", {160'd0, 32'd1}, {160'd0, 32'hFFFFFFFF}, 32'hFFFFFFFF};
`ifdef FILTEZ_SAT_EN
        vecs[4] = '{"big_pos", {160'd0, 32'h40000000}, {160'd0, 32'h40000000}, 32'h7FFFFFFF};
        vecs[5] = '{"big_neg", {160'd0, 32'h80000000}, {160'd0, 32'h7FFFFFFF}, 32'h80000000};
`else
        vecs[4] = '{"big_pos", {160'd0, 32'h40000000}, {160'd0, 32'h40000000}, 32'h00000000};
        vecs[5] = '{"big_neg", {160'd0, 32'h80000000}, {160'd0, 32'h7FFFFFFF}, 32'h00020000};
`endif
        vecs[6] = '{"mixed",
                    {32'hFFFFFFFF, 32'd7, 32'd0, 32'd3, 32'hFFFF3CB0, 32'd100000},
                    {32'd32767, 32'd2, 32'd9, 32'hFFFFFC18, 32'd7, 32'd5},
                    32'd6};
        @(negedge ap_clk);
        #1;
        chk("rst ap_done", 64'(ap_done), 64'd0);
        chk("rst ap_ready", 64'(ap_ready), 64'd0);
        chk("rst ap_idle", 64'(ap_idle), 64'd1);
        chk("rst ce", 64'({bli_ce0, dlti_ce0}), 64'd0);
        chk("rst addr", 64'({bli_address0, dlti_address0}), 64'd0);
        chk("rst ap_return", 64'(ap_return), 64'd0);
        ap_rst = 1'b0;
        for (int v = 0; v < 7; v++) run_vec(vecs[v]);
        // reset in the middle of a run: abort with no ap_done
        load(vecs[1]);
        @(negedge ap_clk);
        ap_start = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge ap_clk);
            ap_start = 1'b0;
        end
        ap_rst = 1'b1;
        #1;
        chk("midrst ap_return", 64'(ap_return), 64'd0);
        chk("midrst ap_done", 64'(ap_done), 64'd0);
        chk("midrst ce", 64'({bli_ce0, dlti_ce0}), 64'd0);
        chk("midrst addr", 64'({bli_address0, dlti_address0}), 64'd0);
        chk("midrst ap_idle", 64'(ap_idle), 64'd1);
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 14; n++) begin
            @(negedge ap_clk);
            #1 seen |= ap_done;
        end
        chk("midrst no_done", 64'(seen), 64'd0);
        run_vec(vecs[1]);
        // start held high for three back-to-back runs, dlti changed between them
        for (int k = 0; k < 6; k++) begin
            bli_mem[k]  = 32'd16384;
            dlti_mem[k] = 32'(k + 1);
        end
        exp_seq = '{32'd21, 32'd12, 32'd100};
        at = '{-1, -1, -1};
        dn = 0;
        @(negedge ap_clk);
        ap_start = 1'b1;
        for (int n = 1; n <= 44; n++) begin
            @(negedge ap_clk);
            #1;
            if (n == 14) chk("b2b idle_restart", 64'(ap_idle), 64'd0);
            if (ap_done && dn < 3) begin
                at[dn] = n;
                chk($sformatf("b2b ret%0d", dn), 64'(ap_return), 64'(exp_seq[dn]));
                dn++;
                for (int k = 0; k < 6; k++) dlti_mem[k] = (dn == 1) ? 32'd2 : (k == 5) ? 32'd100 : 32'd0;
                if (dn == 3) ap_start = 1'b0;
            end
        end
        chk("b2b done0", 64'(at[0]), 64'(13));
        chk("b2b done1", 64'(at[1]), 64'(27));
        chk("b2b done2", 64'(at[2]), 64'(41));
        chk("b2b ret_held", 64'(ap_return), 64'd100);
        chk("b2b idle_end", 64'(ap_idle), 64'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
